// File: rtl/odeme_denetci_pkg.sv
// Shared types and widths for the payment controller and its balance store.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package odeme_pkg;

  localparam int UCRET_W    = 8;
  localparam int BAKIYE_W   = 9;
  localparam int BAKIYE_MAX = 511;

  typedef enum logic [2:0] {
    BOS    = 3'd0,
    OKU    = 3'd1,
    ODE    = 3'd2,
    YAZ    = 3'd3,
    BILDIR = 3'd4
  } durum_t;

  // Top-up add done one bit wider, clamped to the largest storable balance.
  function automatic logic [BAKIYE_W-1:0] doygun_topla(
    input logic [BAKIYE_W-1:0] bakiye,
    input logic [UCRET_W-1:0]  miktar
  );
    logic [BAKIYE_W:0] toplam;
    toplam = {1'b0, bakiye} + {{(BAKIYE_W + 1 - UCRET_W){1'b0}}, miktar};
    return toplam[BAKIYE_W] ? BAKIYE_W'(BAKIYE_MAX) : toplam[BAKIYE_W-1:0];
  endfunction

endpackage

// File: rtl/odeme_denetci_bakiye_bellek.sv
// Per-card balance register file, every entry reset to the opening balance.
// Latency: combinational read; write visible after the clock edge.
// Backpressure: none, one read and one write per cycle always accepted.
module bakiye_bellek
  import odeme_pkg::*;
#(
  parameter int KART_SAYISI      = 8,
  parameter int KART_BIT         = 3,
  parameter int BASLANGIC_BAKIYE = 100
) (
  input  logic                saat,
  input  logic                reset,
  input  logic [KART_BIT-1:0] oku_adr,
  output logic [BAKIYE_W-1:0] oku_dat,
  input  logic                yaz_en,
  input  logic [KART_BIT-1:0] yaz_adr,
  input  logic [BAKIYE_W-1:0] yaz_dat
);

  logic [BAKIYE_W-1:0] mem [KART_SAYISI];

  // Reset restores every card; otherwise a single write per edge.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KART_SAYISI; i++) begin
        mem[i] <= BAKIYE_W'(BASLANGIC_BAKIYE);
      end
    end else if (yaz_en) begin
      mem[yaz_adr] <= yaz_dat;
    end
  end

  assign oku_dat = mem[oku_adr];

endmodule

// File: rtl/odeme_denetci.sv
// Card payment controller: runs purchases through odeme, applies top-ups, reports results.
// Latency: purchase hazir 4 cycles after capture (+ odeme delay); top-up hazir next cycle.
// Backpressure: requests only sampled while idle (mesgul low); ODEME_ISTATISTIK_EN adds counters.
module odeme_denetci
  import odeme_pkg::*;
#(
  parameter int KART_SAYISI      = 8,
  parameter int KART_BIT         = 3,
  parameter int BASLANGIC_BAKIYE = 100,
  parameter int ZAMAN_ASIMI      = 15
) (
  input  logic                saat,
  input  logic                reset,
  input  logic                istek,
  input  logic [KART_BIT-1:0] kart_no,
  input  logic [UCRET_W-1:0]  istek_ucret,
  input  logic                yukle,
  input  logic [UCRET_W-1:0]  yukle_miktar,
  output logic                mesgul,
  output logic                hazir,
  output logic                sonuc_onay,
  output logic [BAKIYE_W-1:0] sonuc_bakiye,
  output logic                hata,
  output logic                basla,
  output logic [UCRET_W-1:0]  ucret,
  output logic [BAKIYE_W-1:0] bakiye,
  input  logic                onay,
  input  logic [BAKIYE_W-1:0] k_bakiye,
  input  logic                bitti
`ifdef ODEME_ISTATISTIK_EN
  ,
  output logic [7:0]          onay_sayisi,
  output logic [7:0]          red_sayisi
`endif
);

  localparam int SAYAC_W = $clog2(ZAMAN_ASIMI + 1);

  durum_t durum_q, durum_d;

  logic [KART_BIT-1:0] kart_q, kart_d;
  logic [UCRET_W-1:0]  ucret_q, ucret_d;
  logic [BAKIYE_W-1:0] bakiye_q, bakiye_d;
  logic [SAYAC_W-1:0]  sayac_q, sayac_d;
  logic                onay_q, onay_d;
  logic [BAKIYE_W-1:0] k_bakiye_q, k_bakiye_d;
  logic                sonuc_onay_q, sonuc_onay_d;
  logic                hata_q, hata_d;
  logic                gecerli_q, gecerli_d;

  logic                kart_gecerli;
  logic [KART_BIT-1:0] oku_adr;
  logic [BAKIYE_W-1:0] oku_dat;
  logic                yaz_en;
  logic [KART_BIT-1:0] yaz_adr;
  logic [BAKIYE_W-1:0] yaz_dat;
  logic [BAKIYE_W-1:0] beklenen;

  // The range check only exists when the index can name a missing card.
  if (KART_SAYISI < (1 << KART_BIT)) begin : g_aralik
    assign kart_gecerli = (int'(kart_no) < KART_SAYISI);
  end else begin : g_tam
    assign kart_gecerli = 1'b1;
  end

  // Balance odeme should return for an approved purchase (wraps at 9 bits).
  assign beklenen = bakiye_q - {{(BAKIYE_W - UCRET_W){1'b0}}, ucret_q};

  bakiye_bellek #(
    .KART_SAYISI      (KART_SAYISI),
    .KART_BIT         (KART_BIT),
    .BASLANGIC_BAKIYE (BASLANGIC_BAKIYE)
  ) u_bellek (
    .saat    (saat),
    .reset   (reset),
    .oku_adr (oku_adr),
    .oku_dat (oku_dat),
    .yaz_en  (yaz_en),
    .yaz_adr (yaz_adr),
    .yaz_dat (yaz_dat)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q <= BOS;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Next state, register updates and balance-store port control.
  always_comb begin
    durum_d      = durum_q;
    kart_d       = kart_q;
    ucret_d      = ucret_q;
    bakiye_d     = bakiye_q;
    sayac_d      = sayac_q;
    onay_d       = onay_q;
    k_bakiye_d   = k_bakiye_q;
    sonuc_onay_d = sonuc_onay_q;
    hata_d       = hata_q;
    gecerli_d    = gecerli_q;
    oku_adr      = kart_q;
    yaz_en       = 1'b0;
    yaz_adr      = kart_q;
    yaz_dat      = k_bakiye_q;

    case (durum_q)
      BOS: begin
        oku_adr = kart_no;
        if (istek || yukle) begin
          kart_d       = kart_no;
          gecerli_d    = kart_gecerli;
          sonuc_onay_d = 1'b0;
          hata_d       = 1'b0;
          if (!kart_gecerli) begin
            hata_d  = 1'b1;
            durum_d = BILDIR;
          end else if (istek) begin
            // A simultaneous top-up is dropped; the purchase wins.
            ucret_d = istek_ucret;
            durum_d = OKU;
          end else begin
            yaz_en       = 1'b1;
            yaz_adr      = kart_no;
            yaz_dat      = doygun_topla(oku_dat, yukle_miktar);
            sonuc_onay_d = 1'b1;
            durum_d      = BILDIR;
          end
        end
      end
      OKU: begin
        bakiye_d = oku_dat;
        sayac_d  = '0;
        durum_d  = ODE;
      end
      ODE: begin
        if (bitti) begin
          onay_d     = onay;
          k_bakiye_d = k_bakiye;
          durum_d    = YAZ;
        end else if (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1)) begin
          hata_d  = 1'b1;
          durum_d = BILDIR;
        end else begin
          sayac_d = sayac_q + SAYAC_W'(1);
        end
      end
      YAZ: begin
        // Only an approval whose remaining balance adds up is committed.
        if (onay_q) begin
          if (k_bakiye_q == beklenen) begin
            yaz_en       = 1'b1;
            sonuc_onay_d = 1'b1;
          end else begin
            hata_d = 1'b1;
          end
        end
        durum_d = BILDIR;
      end
      BILDIR: begin
        durum_d = BOS;
      end
      default: begin
        durum_d = BOS;
      end
    endcase
  end

  // Transaction registers, all cleared by reset.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      kart_q       <= '0;
      ucret_q      <= '0;
      bakiye_q     <= '0;
      sayac_q      <= '0;
      onay_q       <= 1'b0;
      k_bakiye_q   <= '0;
      sonuc_onay_q <= 1'b0;
      hata_q       <= 1'b0;
      gecerli_q    <= 1'b0;
    end else begin
      kart_q       <= kart_d;
      ucret_q      <= ucret_d;
      bakiye_q     <= bakiye_d;
      sayac_q      <= sayac_d;
      onay_q       <= onay_d;
      k_bakiye_q   <= k_bakiye_d;
      sonuc_onay_q <= sonuc_onay_d;
      hata_q       <= hata_d;
      gecerli_q    <= gecerli_d;
    end
  end

  // Strobes are pure state decodes so reset drops them without a clock.
  assign basla        = (durum_q == ODE);
  assign hazir        = (durum_q == BILDIR);
  assign mesgul       = (durum_q != BOS);
  assign ucret        = ucret_q;
  assign bakiye       = bakiye_q;
  assign sonuc_onay   = hazir & sonuc_onay_q;
  assign hata         = hazir & hata_q;
  assign sonuc_bakiye = (hazir && gecerli_q) ? oku_dat : '0;

`ifdef ODEME_ISTATISTIK_EN
  logic satin_q;

  // Remember whether the running transaction is a purchase.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      satin_q <= 1'b0;
    end else if (durum_q == BOS && (istek || yukle)) begin
      satin_q <= istek;
    end
  end

  // Saturating approved/rejected purchase counters, stepped on each report.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      onay_sayisi <= '0;
      red_sayisi  <= '0;
    end else if (hazir && satin_q) begin
      if (sonuc_onay) begin
        if (onay_sayisi != 8'hFF) onay_sayisi <= onay_sayisi + 8'd1;
      end else begin
        if (red_sayisi != 8'hFF) red_sayisi <= red_sayisi + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/odeme_denetci.md
Name: odeme_denetci

Overview:
- Controller directly upstream of the `odeme` payment block, and the consumer of its result.
- Holds a balance register per card and accepts purchase and top-up requests.
- For a purchase it drives `basla`/`ucret`/`bakiye` into `odeme`, waits for `bitti`, checks the result, and writes `k_bakiye` back.
- Reports each completed transaction to the front panel with a one-cycle `hazir` pulse.

Parameters:
- KART_SAYISI, 8, number of card balance registers.
- KART_BIT, 3, card index width; must satisfy 2**KART_BIT >= KART_SAYISI.
- BASLANGIC_BAKIYE, 100, balance every card takes on reset (9-bit).
- ZAMAN_ASIMI, 15, maximum number of cycles in ODE without `bitti` before the transaction aborts.

Ports:
- saat  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- istek  in  1  purchase request; sampled only in BOS.
- kart_no  in  KART_BIT  card index for `istek` or `yukle`.
- istek_ucret  in  8  fare for a purchase.
- yukle  in  1  top-up request; sampled only in BOS.
- yukle_miktar  in  8  top-up amount.
- mesgul  out  1  high in every state except BOS.
- hazir  out  1  one-cycle completion pulse.
- sonuc_onay  out  1  transaction result; valid while `hazir` is high.
- sonuc_bakiye  out  9  card balance after the transaction; valid while `hazir` is high.
- hata  out  1  timeout or inconsistent result; valid while `hazir` is high.
- basla  out  1  start strobe to `odeme`.
- ucret  out  8  fare to `odeme`.
- bakiye  out  9  current card balance to `odeme`.
- onay  in  1  approval from `odeme`.
- k_bakiye  in  9  remaining balance from `odeme`.
- bitti  in  1  done from `odeme`.

Behaviour:
- Reset (reset=0, asynchronous):
  - every balance register = BASLANGIC_BAKIYE; state = BOS;
  - outputs basla, hazir, sonuc_onay, hata, mesgul = 0; ucret = 0, bakiye = 0, sonuc_bakiye = 0.
  - Reset asserted mid-transaction aborts it with no write-back; `basla` drops immediately, without waiting for a clock edge.
- States: BOS, OKU, ODE, YAZ, BILDIR, encoded in 3 bits.
- BOS:
  - `istek`=1 → latch `kart_no` and `istek_ucret`; go to OKU.
  - `istek`=0 and `yukle`=1 → balance[kart] = min(balance + yukle_miktar, 511); sonuc_onay = 1; go to BILDIR.
  - `istek` and `yukle` both high → `istek` wins and `yukle` is dropped; the requester must retry.
  - `kart_no` >= KART_SAYISI → no access; go to BILDIR with hata=1, sonuc_onay=0, sonuc_bakiye=0.
- OKU: register `bakiye` from balance[kart]; go to ODE.
- ODE:
  - basla=1; `ucret` and `bakiye` are held stable.
  - Wait counter is cleared on entry.
  - `bitti`=1 at a clock edge → latch `onay` and `k_bakiye`; go to YAZ.
  - Counter reaching ZAMAN_ASIMI with no `bitti` → hata=1; go to BILDIR with no write-back.
  - `basla` is a state decode: it drops in the cycle after `bitti` is sampled.
- YAZ:
  - onay=1 and k_bakiye == bakiye − ucret → write `k_bakiye`; sonuc_onay=1.
  - onay=1 with any other `k_bakiye` → hata=1; no write.
  - onay=0 → no write; sonuc_onay=0.
  - Go to BILDIR.
- BILDIR: hazir=1 for exactly one cycle; sonuc_bakiye = the card's current balance; go to BOS.
- Latency:
  - Purchase request captured at edge E, `odeme` answering in its first ODE cycle → basla high in cycle E+2, hazir high in cycle E+4.
  - Top-up → hazir high in cycle E+1.
- Arithmetic:
  - Top-up sum is computed 10 bits wide, then saturated to 511.
  - The purchase consistency check uses a 9-bit subtraction; the check applies only when onay=1.

Optional Feature:
- Macro: ODEME_ISTATISTIK_EN.
- Defined:
  - adds outputs onay_sayisi[7:0] and red_sayisi[7:0];
  - on each `hazir` pulse of a purchase, increment onay_sayisi if sonuc_onay=1, otherwise red_sayisi (this includes timeouts);
  - counters saturate at 255 and clear on reset.
- Undefined: those ports and their logic do not exist.

Decomposition:
- Package `odeme_pkg`:
  - state encoding constants (BOS, OKU, ODE, YAZ, BILDIR);
  - UCRET_W = 8, BAKIYE_W = 9, BAKIYE_MAX = 511.
- Sub-module `bakiye_bellek`:
  - register file of KART_SAYISI × 9 bits, reset to BASLANGIC_BAKIYE;
  - one read port and one write port;
  - writes take effect on the clock edge; reads are combinational.

Test Plan:
- Reset; istek kart=2, ucret=14; `odeme` model returns onay=1, k_bakiye=86 in the first ODE cycle → basla=1 with bakiye=100 at E+2; hazir at E+4 with sonuc_onay=1, sonuc_bakiye=86.
- istek kart=3, ucret=200; model returns onay=0, k_bakiye=100 → sonuc_onay=0, sonuc_bakiye=100, balance of card 3 unchanged.
- yukle kart=5, miktar=250, twice → sonuc_bakiye=350, then 511 (saturated).
- istek kart=1, ucret=10; `bitti` held 0 → after 15 ODE cycles hata=1, sonuc_onay=0, balance stays 100.
- istek and yukle in the same cycle on kart=4 (ucret=20, miktar=50) → only the purchase runs, final balance 80; model returns onay=1, k_bakiye=70 instead → hata=1, balance 100.
- reset=0 during ODE → basla=0 at once; after release all balances = 100 and no hazir pulse occurs.
